// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single 16-bit RAM slave.
// Round-robin, one transfer per grant, one idle GAP cycle, bus timeout.
module wb_mem_arbiter #(
  parameter int AW      = 13,
  parameter int TIMEOUT = 15
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [15:0]   m0_dat_i,
  output logic [15:0]   m0_dat_o,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [1:0]    m0_sel_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [15:0]   m1_dat_i,
  output logic [15:0]   m1_dat_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [1:0]    m1_sel_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [AW-1:0] s_adr_o,
  output logic [15:0]   s_dat_o,
  input  logic [15:0]   s_dat_i,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [1:0]    s_sel_o,
  input  logic          s_ack_i
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, BUSY0, BUSY1, GAP
  } state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;

  logic req0, req1;
  logic busy, gnt, req_g, we_g;
  logic ack_g, tmo, pick;
  logic [1:0] sel_g;

  assign req0  = m0_cyc_i & m0_stb_i;
  assign req1  = m1_cyc_i & m1_stb_i;
  assign busy  = (state_q == BUSY0) | (state_q == BUSY1);
  // Outside BUSY the slave address/data follow the last granted master.
  assign gnt   = busy ? (state_q == BUSY1) : last_q;
  assign req_g = gnt ? req1 : req0;
  assign we_g  = gnt ? m1_we_i : m0_we_i;
  assign sel_g = gnt ? m1_sel_i : m0_sel_i;
  assign ack_g = busy & req_g & s_ack_i;
  assign tmo   = (TIMEOUT > 0) & busy & (timer_q == TLAST);
  assign pick  = (req0 & req1) ? prio_q : req1;

  assign s_adr_o  = gnt ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = gnt ? m1_dat_i : m0_dat_i;
  assign s_cyc_o  = busy & req_g;
  assign s_stb_o  = busy & req_g;
  assign s_we_o   = busy & we_g;
  assign s_sel_o  = busy ? sel_g : 2'b11;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = (state_q == BUSY0) & req0 & s_ack_i;
  assign m1_ack_o = (state_q == BUSY1) & req1 & s_ack_i;
  assign m0_err_o = (state_q == BUSY0) & req0 & tmo & ~s_ack_i;
  assign m1_err_o = (state_q == BUSY1) & req1 & tmo & ~s_ack_i;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    last_d  = last_q;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = pick ? BUSY1 : BUSY0;
          last_d  = pick;
          timer_d = '0;
        end
      end
      BUSY0, BUSY1: begin
        if (timer_q != '1) timer_d = timer_q + TW'(1);
        // Ack beats a coincident timeout; an abort keeps priority.
        if (ack_g) begin
          state_d = GAP;
          prio_d  = ~gnt;
        end else if (!req_g) begin
          state_d = GAP;
        end else if (tmo) begin
          state_d = GAP;
          prio_d  = ~gnt;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      last_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      last_q  <= last_d;
      timer_q <= timer_d;
    end
  end

endmodule
